seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parameterised serial bit-pattern detector and successor to the fixed single-pattern lab detector (serial input a, match output y).
- Samples one bit per enabled clock, compares the last PAT_W bits against a run-time loadable pattern, and pulses y for one cycle per match.
- Supports overlapping and non-overlapping modes, with an optional saturating match counter.
- Used as a standalone lab block and as a framing/sync-word detector in later labs.

Parameters:
- PAT_W, 4, pattern length in bits (2..16).
- DEF_PAT, 4'b1101 (sized to PAT_W), pattern loaded at reset.
- CNT_W, 8, match counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-high.
- en  in  1  sample enable; a is consumed only when en=1.
- a  in  1  serial data bit.
- load  in  1  latch pattern input and restart detection.
- pattern  in  PAT_W  new pattern; bit PAT_W-1 is the oldest (first-received) bit, bit 0 the newest.
- overlap  in  1  1 = overlapping matches allowed; 0 = non-overlapping (type seq_det_pkg::mode_e).
- cnt_clr  in  1  synchronous clear of match_cnt.
- y  out  1  registered one-cycle match pulse.
- match_cnt  out  CNT_W  saturating count of matches.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - pat_q=DEF_PAT, hist=0, fill=0, y=0, match_cnt=0.
  - A reset asserted mid-pattern discards all partial history.
- State, held in fill (0..PAT_W, saturating):
  - FILLING while fill<PAT_W.
  - ARMED when fill==PAT_W.
- Priority each edge: reset > load > en.
- load=1:
  - pat_q<=pattern, fill<=0, y<=0.
  - a is not sampled that cycle; match_cnt is unchanged.
- en=1, load=0:
  - hist<={hist[PAT_W-2:0],a}.
  - fill_next=min(fill+1,PAT_W).
  - hit = (fill_next==PAT_W) && ({hist[PAT_W-2:0],a}==pat_q).
  - y<=hit, so y is high during the cycle after the edge that sampled the completing bit (latency 1).
- On hit:
  - overlap=1: fill stays PAT_W, so the next matching bit can hit immediately.
  - overlap=0: fill<=0, so at least PAT_W further bits are needed before the next hit.
- en=0, load=0: hist and fill hold; y<=0.
- overlap is sampled at the hit edge; changing it mid-stream takes effect at the next hit.
- y is never high for two consecutive cycles unless overlap=1, the pattern is self-overlapping (e.g. all ones), and en is high on both edges.

Optional Feature:
- Macro: SEQ_DET_CNT_EN.
- Defined:
  - match_cnt increments by 1 on each hit and saturates at 2^CNT_W-1.
  - cnt_clr=1 forces 0; when cnt_clr and hit coincide, clear wins and the result is 0.
- Undefined:
  - No counter logic is built; match_cnt is tied to 0 and cnt_clr is ignored.
  - y behaviour is identical in both builds.

Decomposition:
- Package seq_det_pkg:
  - typedef enum logic {NON_OVERLAP=0, OVERLAP=1} mode_e.
  - localparam PAT_W_MAX=16.
  - Helper function fill_inc(fill, PAT_W) implementing the saturating fill increment.
- Sub-module sat_counter #(W):
  - Inputs: clk, reset, clr, inc. Output: q.
  - Instantiated only under SEQ_DET_CNT_EN.
- Shift register, fill and compare logic stay in the top module.

Test Plan (PAT_W=4, DEF_PAT=1101, CNT_W=8 unless stated):
1. reset, overlap=1, en=1, a=1,1,0,1,1,0,1 -> y high only in the cycles after bit 4 and bit 7; match_cnt=2.
2. overlap=0, same stream -> y after bit 4 only; appending 1,1,0,1 -> second y after bit 11; match_cnt=2.
3. Overlap stream 1,1,0,1 with en=0 for 3 cycles between each bit -> single y after bit 4; y=0 during every en=0 cycle.
4. a=1,1,0 then reset, then a=1 -> no y; resume with 1,0,1 -> y after the 4th post-reset bit.
5. After a=1,1,0, load with pattern=0000, then a=0,0,0 -> no y; a 4th 0 -> y; a 5th 0 with overlap=1 -> y again.
6. CNT_W=2, pattern 1111, overlap=1, eight consecutive 1s -> 5 y pulses, match_cnt holds at 3.
   - cnt_clr held during the 8th bit's hit -> match_cnt=0 next cycle.
   - Build without SEQ_DET_CNT_EN -> match_cnt stays 0 throughout.

Source files
------------

// File: rtl/seq_detector_param_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared types and helpers for the parameterised serial pattern detector.
//   mode_e     : overlap mode selector carried on the detector interface
//   PAT_W_MAX  : largest supported pattern length
//   FILL_W     : width of the fill counter (holds 0..PAT_W_MAX)
//   fill_inc() : saturating increment of the fill counter
// -----------------------------------------------------------------------------
package seq_det_pkg;

  typedef enum logic {
    NON_OVERLAP = 1'b0,
    OVERLAP     = 1'b1
  } mode_e;

  localparam int PAT_W_MAX = 16;
  localparam int FILL_W    = $clog2(PAT_W_MAX + 1);

  // Saturating fill increment: counts sampled bits up to the pattern length.
  function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] fill,
                                                 input logic [FILL_W-1:0] pat_w);
    if (fill >= pat_w) begin
      fill_inc = pat_w;
    end else begin
      fill_inc = fill + FILL_W'(1'b1);
    end
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// -----------------------------------------------------------------------------
// seq_detector_param_if
// Bundles the data/control signals of the serial pattern detector.
//   en, a      : sample enable and serial data bit
//   load       : latch `pattern` and restart detection
//   pattern    : new pattern, MSB is the first-received bit
//   overlap    : overlapping / non-overlapping match mode
//   cnt_clr    : synchronous clear of the match counter
//   y          : registered one-cycle match pulse
//   match_cnt  : saturating match count (zero when the counter is not built)
// Modports: master drives the controls, slave is the detector.
// -----------------------------------------------------------------------------
interface seq_detector_param_if
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);

  logic             en;
  logic             a;
  logic             load;
  logic [PAT_W-1:0] pattern;
  mode_e            overlap;
  logic             cnt_clr;
  logic             y;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output en, a, load, pattern, overlap, cnt_clr,
    input  y, match_cnt
  );

  modport slave (
    input  en, a, load, pattern, overlap, cnt_clr,
    output y, match_cnt
  );

endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// W-bit up counter that saturates at all-ones.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (highest priority)
//   clr   : synchronous clear, wins over inc
//   inc   : increment request
//   q     : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear beats increment, increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
// Serial bit-pattern detector. One bit is shifted in per enabled clock; once
// PAT_W bits have been collected since the last restart, the last PAT_W bits
// are compared with a run-time loadable pattern and y pulses for one cycle on
// each match. Overlapping or non-overlapping matching is selected by `overlap`.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset
//   bus    : seq_detector_param_if.slave (en, a, load, pattern, overlap,
//            cnt_clr in; y, match_cnt out)
//
// Build option: define SEQ_DET_CNT_EN to build the saturating match counter.
// Without it match_cnt is tied to zero and cnt_clr is ignored.
// -----------------------------------------------------------------------------
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(4'b1101),
  parameter int               CNT_W   = 8
) (
  input logic                  clk,
  input logic                  reset,
  seq_detector_param_if.slave  bus
);

  // fill value meaning "PAT_W valid bits collected" (ARMED)
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-1:0]  pat_d;
  logic [PAT_W-1:0]  hist_q;
  logic [PAT_W-1:0]  hist_d;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;
  logic              y_q;
  logic              y_d;

  logic [PAT_W-1:0]  shifted_s;
  logic [FILL_W-1:0] fill_nxt_s;
  logic              hit_s;

  // Next-state: load restarts detection, en shifts a bit in and evaluates a hit.
  always_comb begin
    pat_d      = pat_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    y_d        = 1'b0;
    hit_s      = 1'b0;
    shifted_s  = {hist_q[PAT_W-2:0], bus.a};
    fill_nxt_s = fill_inc(fill_q, FILL_FULL);

    if (bus.load) begin
      pat_d  = bus.pattern;
      fill_d = '0;
      y_d    = 1'b0;
    end else if (bus.en) begin
      hist_d = shifted_s;
      hit_s  = (fill_nxt_s == FILL_FULL) && (shifted_s == pat_q);
      // A non-overlapping hit consumes the matched bits: restart the fill.
      if (hit_s && (bus.overlap == NON_OVERLAP)) begin
        fill_d = '0;
      end else begin
        fill_d = fill_nxt_s;
      end
      y_d = hit_s;
    end else begin
      y_d = 1'b0;
    end
  end

  // State registers; reset discards any partial history.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= DEF_PAT;
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= y_d;
    end
  end

  assign bus.y = y_q;

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_s;

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.cnt_clr),
    .inc   (hit_s),
    .q     (cnt_s)
  );

  assign bus.match_cnt = cnt_s;
`else
  assign bus.match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
// Directed bench for seq_detector_param. dut1: PAT_W=4, DEF_PAT=1101, CNT_W=8.
// dut2: PAT_W=4, DEF_PAT=1111, CNT_W=2 for the saturation scenario.
// Counter expectations follow the SEQ_DET_CNT_EN build option.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;
  import seq_det_pkg::*;

`ifdef SEQ_DET_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk;
  logic reset;
  int   total;
  int   bad;

  seq_detector_param_if #(.PAT_W(4), .CNT_W(8)) bus1 ();
  seq_detector_param_if #(.PAT_W(4), .CNT_W(2)) bus2 ();

  seq_detector_param #(.PAT_W(4), .DEF_PAT(4'b1101), .CNT_W(8)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  seq_detector_param #(.PAT_W(4), .DEF_PAT(4'b1111), .CNT_W(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous reset of both instances for one edge.
  task automatic do_reset();
    reset = 1'b1;
    bus1.en = 1'b1; bus1.a = 1'b1; bus1.load = 1'b0; bus1.cnt_clr = 1'b0;
    bus2.en = 1'b0; bus2.a = 1'b0; bus2.load = 1'b0; bus2.cnt_clr = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    bus1.en = 1'b0;
  endtask

  // One clock on dut1 with the given en/a; returns #1 after the edge.
  task automatic tick1(input logic en_v, input logic a_v);
    bus1.en = en_v; bus1.a = a_v; bus1.load = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus1.en = 1'b1; bus1.a = 1'b1; bus1.load = 1'b0; bus1.cnt_clr = 1'b0;
    bus1.pattern = 4'b0000; bus1.overlap = OVERLAP;
    bus2.en = 1'b0; bus2.a = 1'b0; bus2.load = 1'b0; bus2.cnt_clr = 1'b0;
    bus2.pattern = 4'b0000; bus2.overlap = OVERLAP;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus1.y !== 1'b0) begin
      bad++; $display("FAIL reset_y: got %b want 0", bus1.y);
    end
    total++;
    if (bus1.match_cnt !== 8'd0) begin
      bad++; $display("FAIL reset_cnt: got %0d want 0", bus1.match_cnt);
    end
    reset = 1'b0;
    bus1.en = 1'b0;
  endtask

  task automatic test_overlap();
    logic s [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic exp_y;
    do_reset();
    bus1.overlap = OVERLAP;
    for (int i = 0; i < 7; i++) begin
      tick1(1'b1, s[i]);
      exp_y = (i == 3) || (i == 6);
      total++;
      if (bus1.y !== exp_y) begin
        bad++; $display("FAIL ovl_y bit%0d: got %b want %b", i + 1, bus1.y, exp_y);
      end
    end
    tick1(1'b0, 1'b0);
    total++;
    if (bus1.match_cnt !== (CNT_ON ? 8'd2 : 8'd0)) begin
      bad++; $display("FAIL ovl_cnt: got %0d want %0d", bus1.match_cnt, CNT_ON ? 2 : 0);
    end
  endtask

  task automatic test_non_overlap();
    logic s [11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                     1'b1, 1'b1, 1'b0, 1'b1};
    logic exp_y;
    do_reset();
    bus1.overlap = NON_OVERLAP;
    for (int i = 0; i < 11; i++) begin
      tick1(1'b1, s[i]);
      exp_y = (i == 3) || (i == 10);
      total++;
      if (bus1.y !== exp_y) begin
        bad++; $display("FAIL novl_y bit%0d: got %b want %b", i + 1, bus1.y, exp_y);
      end
    end
    tick1(1'b0, 1'b0);
    total++;
    if (bus1.match_cnt !== (CNT_ON ? 8'd2 : 8'd0)) begin
      bad++; $display("FAIL novl_cnt: got %0d want %0d", bus1.match_cnt, CNT_ON ? 2 : 0);
    end
  endtask

  task automatic test_enable_gaps();
    logic s [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic exp_y;
    do_reset();
    bus1.overlap = OVERLAP;
    for (int i = 0; i < 4; i++) begin
      tick1(1'b1, s[i]);
      exp_y = (i == 3);
      total++;
      if (bus1.y !== exp_y) begin
        bad++; $display("FAIL gap_y bit%0d: got %b want %b", i + 1, bus1.y, exp_y);
      end
      for (int k = 0; k < 3; k++) begin
        tick1(1'b0, 1'b1);
        total++;
        if (bus1.y !== 1'b0) begin
          bad++; $display("FAIL gap_idle_y bit%0d idle%0d: got %b want 0", i + 1, k, bus1.y);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic pre [3]  = '{1'b1, 1'b1, 1'b0};
    logic post [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic exp_y;
    do_reset();
    bus1.overlap = OVERLAP;
    for (int i = 0; i < 3; i++) begin
      tick1(1'b1, pre[i]);
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick1(1'b1, post[i]);
      exp_y = (i == 3);
      total++;
      if (bus1.y !== exp_y) begin
        bad++; $display("FAIL rstmid_y bit%0d: got %b want %b", i + 1, bus1.y, exp_y);
      end
    end
  endtask

  task automatic test_load();
    logic pre [3] = '{1'b1, 1'b1, 1'b0};
    logic exp_y;
    do_reset();
    bus1.overlap = OVERLAP;
    for (int i = 0; i < 3; i++) begin
      tick1(1'b1, pre[i]);
    end
    bus1.load = 1'b1; bus1.pattern = 4'b0000; bus1.en = 1'b1; bus1.a = 1'b0;
    @(posedge clk); #1;
    bus1.load = 1'b0;
    total++;
    if (bus1.y !== 1'b0) begin
      bad++; $display("FAIL load_y: got %b want 0", bus1.y);
    end
    total++;
    if (bus1.match_cnt !== 8'd0) begin
      bad++; $display("FAIL load_cnt: got %0d want 0", bus1.match_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      tick1(1'b1, 1'b0);
      exp_y = (i >= 3);
      total++;
      if (bus1.y !== exp_y) begin
        bad++; $display("FAIL load_zero_y bit%0d: got %b want %b", i + 1, bus1.y, exp_y);
      end
    end
  endtask

  task automatic test_saturate();
    logic       exp_y;
    logic [1:0] exp_cnt;
    int         pulses;
    do_reset();
    pulses = 0;
    bus2.overlap = OVERLAP;
    for (int i = 0; i < 8; i++) begin
      bus2.en = 1'b1; bus2.a = 1'b1; bus2.load = 1'b0;
      bus2.cnt_clr = (i == 7);
      @(posedge clk); #1;
      exp_y = (i >= 3);
      case (i)
        3:       exp_cnt = 2'd1;
        4:       exp_cnt = 2'd2;
        5, 6:    exp_cnt = 2'd3;
        default: exp_cnt = 2'd0;
      endcase
      if (!CNT_ON) exp_cnt = 2'd0;
      if (bus2.y === 1'b1) pulses++;
      total++;
      if (bus2.y !== exp_y) begin
        bad++; $display("FAIL sat_y bit%0d: got %b want %b", i + 1, bus2.y, exp_y);
      end
      total++;
      if (bus2.match_cnt !== exp_cnt) begin
        bad++; $display("FAIL sat_cnt bit%0d: got %0d want %0d", i + 1, bus2.match_cnt, exp_cnt);
      end
    end
    bus2.en = 1'b0; bus2.cnt_clr = 1'b0;
    total++;
    if (pulses != 5) begin
      bad++; $display("FAIL sat_pulses: got %0d want 5", pulses);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_overlap();
    test_non_overlap();
    test_enable_gaps();
    test_reset_mid();
    test_load();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
